// File: rtl/counter_sequencer.sv
// Sequencer for an external 8-bit counter: up/down wrap, ping-pong and single-sweep runs paced by a prescaler.
// Commands are registered and appear one cycle after the prescaler tick; there is no backpressure, stop aborts at once.
`timescale 1ns/1ps
module counter_sequencer #(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter logic [7:0]  HI_LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [7:0] cnt_q,
    output logic       cnt_clr,
    output logic       cnt_load,
    output logic [7:0] cnt_din,
    output logic       cnt_en,
    output logic       cnt_ud,
    output logic       busy,
    output logic       wrap,
    output logic       done
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] M_UP_WRAP = 2'b00;
    localparam logic [1:0] M_DN_WRAP = 2'b01;
    localparam logic [1:0] M_PING    = 2'b10;
    localparam logic [1:0] M_SWEEP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    mode_q, mode_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_ud_q, cnt_ud_d;
    logic          busy_q, busy_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (presc_q == PS_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        cnt_clr_d  = 1'b0;
        cnt_load_d = 1'b0;
        cnt_en_d   = 1'b0;
        cnt_ud_d   = cnt_ud_q;
        wrap_d     = 1'b0;
        done_d     = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    if (start) begin
                        mode_d = mode;
                        if (mode == M_DN_WRAP) begin
                            cnt_load_d = 1'b1;
                            state_d    = S_DOWN;
                        end else begin
                            cnt_clr_d = 1'b1;
                            state_d   = S_UP;
                        end
                    end
                end

                S_UP: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (cnt_q < HI_LIMIT) begin
                            cnt_en_d = 1'b1;
                            cnt_ud_d = 1'b0;
                        end else begin
                            case (mode_q)
                                M_PING: begin
                                    cnt_en_d = 1'b1;
                                    cnt_ud_d = 1'b1;
                                    wrap_d   = 1'b1;
                                    state_d  = S_DOWN;
                                end
                                M_SWEEP: begin
                                    done_d  = 1'b1;
                                    state_d = S_IDLE;
                                end
                                // Down-wrap never sits in UP; treat it like up-wrap.
                                default: begin
                                    cnt_clr_d = 1'b1;
                                    wrap_d    = 1'b1;
                                end
                            endcase
                        end
                    end
                end

                S_DOWN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (cnt_q > HI_LIMIT) begin
                            // Counter escaped the legal range: pull it back to the top quietly.
                            cnt_load_d = 1'b1;
                        end else if (cnt_q != 8'd0) begin
                            cnt_en_d = 1'b1;
                            cnt_ud_d = 1'b1;
                        end else if (mode_q == M_PING) begin
                            cnt_en_d = 1'b1;
                            cnt_ud_d = 1'b0;
                            wrap_d   = 1'b1;
                            state_d  = S_UP;
                        end else begin
                            cnt_load_d = 1'b1;
                            wrap_d     = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            mode_q     <= M_UP_WRAP;
            cnt_clr_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_ud_q   <= 1'b0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            cnt_clr_q  <= cnt_clr_d;
            cnt_load_q <= cnt_load_d;
            cnt_en_q   <= cnt_en_d;
            cnt_ud_q   <= cnt_ud_d;
            busy_q     <= busy_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    assign cnt_clr  = cnt_clr_q;
    assign cnt_load = cnt_load_q;
    assign cnt_din  = HI_LIMIT;
    assign cnt_en   = cnt_en_q;
    assign cnt_ud   = cnt_ud_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;
    assign done     = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with PRESCALE=4, HI_LIMIT=5 driving a behavioural 8-bit counter.
`timescale 1ns/1ps
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] cnt_q;
    logic       cnt_clr;
    logic       cnt_load;
    logic [7:0] cnt_din;
    logic       cnt_en;
    logic       cnt_ud;
    logic       busy;
    logic       wrap;
    logic       done;

    logic [7:0] ctr = 8'd7;
    logic       ovr_en;
    logic [7:0] ovr_val;
    logic [7:0] obs_pk;

    int vec  = 0;
    int errs = 0;

    // Packed view {clr, load, en, busy, wrap, done}; cnt_ud is checked separately.
    localparam logic [7:0] P_IDLE  = 8'b00_000000;
    localparam logic [7:0] P_BUSY  = 8'b00_000100;
    localparam logic [7:0] P_CLR   = 8'b00_100100;
    localparam logic [7:0] P_CLRW  = 8'b00_100110;
    localparam logic [7:0] P_LOAD  = 8'b00_010100;
    localparam logic [7:0] P_LOADW = 8'b00_010110;
    localparam logic [7:0] P_EN    = 8'b00_001100;
    localparam logic [7:0] P_ENW   = 8'b00_001110;
    localparam logic [7:0] P_DONE  = 8'b00_000001;

    always #5 clk = ~clk;

    assign cnt_q  = ctr;
    assign obs_pk = {2'b00, cnt_clr, cnt_load, cnt_en, busy, wrap, done};

    always @(posedge clk) begin
        if (ovr_en)        ctr <= ovr_val;
        else if (cnt_clr)  ctr <= 8'd0;
        else if (cnt_load) ctr <= cnt_din;
        else if (cnt_en)   ctr <= cnt_ud ? ctr - 8'd1 : ctr + 8'd1;
    end

    counter_sequencer #(
        .PRESCALE(4),
        .HI_LIMIT(8'd5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .cnt_q   (cnt_q),
        .cnt_clr (cnt_clr),
        .cnt_load(cnt_load),
        .cnt_din (cnt_din),
        .cnt_en  (cnt_en),
        .cnt_ud  (cnt_ud),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        vec++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // One prescaler period: quiet cycle before the pulse, the pulse, then the counter value.
    task automatic tick_chk(input string tag, input logic [7:0] pulse, input logic ud, input logic [7:0] q);
        step(2);
        chk({tag, "_pre"}, obs_pk, P_BUSY);
        step(1);
        chk({tag, "_pulse"}, obs_pk, pulse);
        if (pulse[3]) chk({tag, "_ud"}, {7'b0, cnt_ud}, {7'b0, ud});
        step(1);
        chk({tag, "_q"}, ctr, q);
    endtask

    task automatic launch(input string tag, input logic [1:0] m, input logic [7:0] pulse, input logic [7:0] q);
        mode  = m;
        start = 1'b1;
        step(1);
        chk({tag, "_launch"}, obs_pk, pulse);
        start = 1'b0;
        step(1);
        chk({tag, "_launch_q"}, ctr, q);
    endtask

    task automatic abort(input string tag);
        stop = 1'b1;
        step(1);
        chk({tag, "_stop"}, obs_pk, P_IDLE);
        stop = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'b00;
        ovr_en  = 1'b0;
        ovr_val = 8'd0;
        step(2);
        chk("rst_out", obs_pk, P_IDLE);
        chk("rst_ud", {7'b0, cnt_ud}, 8'd0);
        chk("din", cnt_din, 8'd5);
        reset = 1'b1;
        step(1);
        chk("rel_idle", obs_pk, P_IDLE);
        step(3);
        chk("idle_nostart", obs_pk, P_IDLE);

        // Up-wrap.
        launch("m0", 2'b00, P_CLR, 8'd0);
        for (int k = 1; k <= 5; k++) tick_chk($sformatf("m0_up%0d", k), P_EN, 1'b0, 8'(k));
        tick_chk("m0_wrap", P_CLRW, 1'b0, 8'd0);
        abort("m0");

        // Down-wrap; mode input changed mid-run and counter forced out of range.
        launch("m1", 2'b01, P_LOAD, 8'd5);
        mode    = 2'b00;
        ovr_val = 8'd9;
        ovr_en  = 1'b1;
        step(1);
        ovr_en = 1'b0;
        chk("m1_ovr_q", ctr, 8'd9);
        step(1);
        chk("m1_oor_pre", obs_pk, P_BUSY);
        step(1);
        chk("m1_oor_load", obs_pk, P_LOAD);
        step(1);
        chk("m1_oor_q", ctr, 8'd5);
        for (int k = 1; k <= 5; k++) tick_chk($sformatf("m1_dn%0d", k), P_EN, 1'b1, 8'(5 - k));
        tick_chk("m1_wrap", P_LOADW, 1'b0, 8'd5);
        abort("m1");

        // Ping-pong.
        launch("m2", 2'b10, P_CLR, 8'd0);
        for (int k = 1; k <= 5; k++) tick_chk($sformatf("m2_up%0d", k), P_EN, 1'b0, 8'(k));
        tick_chk("m2_turn_top", P_ENW, 1'b1, 8'd4);
        for (int k = 1; k <= 4; k++) tick_chk($sformatf("m2_dn%0d", k), P_EN, 1'b1, 8'(4 - k));
        tick_chk("m2_turn_bot", P_ENW, 1'b0, 8'd1);
        abort("m2");

        // Single sweep with start held high: done, then relaunch from IDLE.
        mode  = 2'b11;
        start = 1'b1;
        step(1);
        chk("m3_launch", obs_pk, P_CLR);
        step(1);
        chk("m3_launch_q", ctr, 8'd0);
        for (int k = 1; k <= 5; k++) tick_chk($sformatf("m3_up%0d", k), P_EN, 1'b0, 8'(k));
        step(2);
        chk("m3_done_pre", obs_pk, P_BUSY);
        step(1);
        chk("m3_done", obs_pk, P_DONE);
        step(1);
        chk("m3_relaunch", obs_pk, P_CLR);
        chk("m3_hold_q", ctr, 8'd5);
        step(1);
        chk("m3_relaunch_q", ctr, 8'd0);
        for (int k = 1; k <= 3; k++) tick_chk($sformatf("m3b_up%0d", k), P_EN, 1'b0, 8'(k));

        // stop and start together at q=3.
        stop = 1'b1;
        step(1);
        chk("ss_out", obs_pk, P_IDLE);
        chk("ss_q", ctr, 8'd3);
        stop  = 1'b0;
        start = 1'b0;
        step(4);
        chk("ss_idle", obs_pk, P_IDLE);
        chk("ss_q_hold", ctr, 8'd3);

        // Asynchronous reset while a step pulse is on the bus.
        launch("m2r", 2'b10, P_CLR, 8'd0);
        step(3);
        chk("rr_pulse", obs_pk, P_EN);
        #2 reset = 1'b0;
        #1;
        chk("rr_async", obs_pk, P_IDLE);
        chk("rr_async_ud", {7'b0, cnt_ud}, 8'd0);
        step(1);
        reset = 1'b1;
        chk("rr_q", ctr, 8'd0);
        step(1);
        chk("rr_release", obs_pk, P_IDLE);
        step(6);
        chk("rr_idle", obs_pk, P_IDLE);
        chk("rr_q_hold", ctr, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
